// File: rtl/sdr_sdram_responder.sv
// SDR SDRAM device emulator answering the controller's SDR_16 pads.
// Decodes commands, tracks open rows per bank and serves bursts from an internal RAM.
module sdr_sdram_responder #(
   parameter int MEM_AW = 12,
   parameter int ROW_W  = 13,
   parameter int COL_W  = 9,
   parameter int BA_W   = 2
) (
   input  logic            sdram_clk,
   input  logic            sdram_rst_n,
   input  logic            cke_pad_i,
   input  logic            cs_n_pad_i,
   input  logic            ras_pad_i,
   input  logic            cas_pad_i,
   input  logic            we_pad_i,
   input  logic [BA_W-1:0] ba_pad_i,
   input  logic [12:0]     a_pad_i,
   input  logic [1:0]      dqm_pad_i,
   input  logic [15:0]     dq_i,
   output logic [15:0]     dq_o,
   output logic            dq_oe,
   output logic            protocol_err,
   output logic [15:0]     refresh_cnt
);
   localparam int NB     = 2 ** BA_W;
   localparam int FULL_W = BA_W + ROW_W + COL_W;

   typedef enum logic [2:0] {
      CMD_LMR = 3'b000, CMD_REF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011,
      CMD_WR  = 3'b100, CMD_RD  = 3'b101, CMD_BST = 3'b110, CMD_NOP = 3'b111
   } cmd_t;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_READ = 2'd1, ST_WRITE = 2'd2} burst_state_t;

   burst_state_t     burst_state_r, burst_state_s;
   cmd_t             cmd_s;
   logic [NB-1:0]    bank_open_r;
   logic [ROW_W-1:0] bank_row_r [NB];
   logic [1:0]       bl_code_r;
   logic             cl3_r;
   logic [BA_W-1:0]  burst_ba_r, issue_ba_s;
   logic [ROW_W-1:0] burst_row_r, issue_row_s;
   logic [COL_W-1:0] burst_col_r, issue_col_s, beat_col_s, col_mask_s;
   logic [2:0]       burst_cnt_r, issue_cnt_s, next_cnt_s, bl_max_s;
   logic             burst_ap_r, issue_ap_s;
   logic             start_s, issue_s, issue_rd_s, last_s, rw_ok_s, pre_hit_s, lmr_ok_s;
   logic [FULL_W-1:0] full_addr_s;
   logic [MEM_AW-1:0] ram_addr_s;
   logic [15:0]      mem_r [2**MEM_AW];
   logic             p1_v_r, p2_v_r;
   logic [15:0]      p1_d_r, p2_d_r;

   // Command decode; a deselected or clock-disabled cycle is a NOP.
   always_comb begin
      cmd_s = CMD_NOP;
      if (cke_pad_i && !cs_n_pad_i) begin
         cmd_s = cmd_t'({ras_pad_i, cas_pad_i, we_pad_i});
      end else begin
         cmd_s = CMD_NOP;
      end
   end

   assign rw_ok_s   = ((cmd_s == CMD_RD) || (cmd_s == CMD_WR)) && bank_open_r[ba_pad_i];
   assign pre_hit_s = (cmd_s == CMD_PRE) && (a_pad_i[10] || (ba_pad_i == burst_ba_r));
   assign lmr_ok_s  = (a_pad_i[2:0] <= 3'b011) && !a_pad_i[3] &&
                      ((a_pad_i[6:4] == 3'b010) || (a_pad_i[6:4] == 3'b011));

   // Last beat index of the programmed burst length.
   always_comb begin
      case (bl_code_r)
         2'd0:    bl_max_s = 3'd0;
         2'd1:    bl_max_s = 3'd1;
         2'd2:    bl_max_s = 3'd3;
         2'd3:    bl_max_s = 3'd7;
         default: bl_max_s = 3'd0;
      endcase
   end

   // Burst sequencer: a new READ/WRITE issues beat 0 on its own edge, later beats follow.
   always_comb begin
      burst_state_s = burst_state_r;
      next_cnt_s    = burst_cnt_r;
      start_s       = 1'b0;
      issue_s       = 1'b0;
      issue_rd_s    = 1'b0;
      last_s        = 1'b0;
      issue_ba_s    = burst_ba_r;
      issue_row_s   = burst_row_r;
      issue_col_s   = burst_col_r;
      issue_cnt_s   = burst_cnt_r;
      issue_ap_s    = burst_ap_r;
      if (rw_ok_s) begin
         start_s     = 1'b1;
         issue_s     = 1'b1;
         issue_rd_s  = (cmd_s == CMD_RD);
         issue_ba_s  = ba_pad_i;
         issue_row_s = bank_row_r[ba_pad_i];
         issue_col_s = a_pad_i[COL_W-1:0];
         issue_cnt_s = 3'd0;
         issue_ap_s  = a_pad_i[10];
         if (bl_max_s == 3'd0) begin
            burst_state_s = ST_IDLE;
            last_s        = 1'b1;
         end else begin
            burst_state_s = issue_rd_s ? ST_READ : ST_WRITE;
            next_cnt_s    = 3'd1;
         end
      end else if (cke_pad_i && (burst_state_r != ST_IDLE)) begin
         if (cmd_s == CMD_BST) begin
            burst_state_s = ST_IDLE;
         end else begin
            issue_s    = 1'b1;
            issue_rd_s = (burst_state_r == ST_READ);
            if (burst_cnt_r == bl_max_s) begin
               last_s        = 1'b1;
               burst_state_s = ST_IDLE;
            end else if (pre_hit_s) begin
               burst_state_s = ST_IDLE;
            end else begin
               next_cnt_s = burst_cnt_r + 3'd1;
            end
         end
      end else begin
         burst_state_s = burst_state_r;
      end
   end

   // Sequential wrap inside the BL-aligned column block.
   assign col_mask_s  = COL_W'(bl_max_s);
   assign beat_col_s  = (issue_col_s & ~col_mask_s) | ((issue_col_s + COL_W'(issue_cnt_s)) & col_mask_s);
   assign full_addr_s = {issue_ba_s, issue_row_s, beat_col_s};
   assign ram_addr_s  = full_addr_s[MEM_AW-1:0];

   // Burst state register.
   always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
      if (!sdram_rst_n) burst_state_r <= ST_IDLE;
      else if (cke_pad_i) burst_state_r <= burst_state_s;
   end

   // Mode, bank tracking, burst context, error flag and refresh counter.
   always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
      if (!sdram_rst_n) begin
         bank_open_r  <= '0;
         bl_code_r    <= 2'd0;
         cl3_r        <= 1'b0;
         burst_ba_r   <= '0;
         burst_row_r  <= '0;
         burst_col_r  <= '0;
         burst_cnt_r  <= 3'd0;
         burst_ap_r   <= 1'b0;
         protocol_err <= 1'b0;
         refresh_cnt  <= 16'd0;
      end else if (cke_pad_i) begin
         burst_cnt_r <= next_cnt_s;
         if (start_s) begin
            burst_ba_r  <= issue_ba_s;
            burst_row_r <= issue_row_s;
            burst_col_r <= issue_col_s;
            burst_ap_r  <= issue_ap_s;
         end
         if (last_s && issue_ap_s) bank_open_r[issue_ba_s] <= 1'b0;
         case (cmd_s)
            CMD_LMR: begin
               if (lmr_ok_s) begin
                  bl_code_r <= a_pad_i[1:0];
                  cl3_r     <= a_pad_i[4];
               end
               if (!lmr_ok_s || (|bank_open_r)) protocol_err <= 1'b1;
            end
            CMD_REF: begin
               refresh_cnt <= refresh_cnt + 16'd1;
               if (|bank_open_r) protocol_err <= 1'b1;
            end
            CMD_PRE: begin
               if (a_pad_i[10]) bank_open_r <= '0;
               else bank_open_r[ba_pad_i] <= 1'b0;
            end
            CMD_ACT: begin
               if (bank_open_r[ba_pad_i]) protocol_err <= 1'b1;
               bank_open_r[ba_pad_i] <= 1'b1;
               bank_row_r[ba_pad_i]  <= a_pad_i[ROW_W-1:0];
            end
            CMD_RD, CMD_WR: begin
               if (!bank_open_r[ba_pad_i]) protocol_err <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Data RAM with per-byte write mask; contents survive reset.
   always_ff @(posedge sdram_clk) begin
      if (issue_s && !issue_rd_s) begin
         if (!dqm_pad_i[0]) mem_r[ram_addr_s][7:0]  <= dq_i[7:0];
         if (!dqm_pad_i[1]) mem_r[ram_addr_s][15:8] <= dq_i[15:8];
      end
   end

   // CAS-latency read pipeline; a WRITE command flushes beats still in flight.
   always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
      if (!sdram_rst_n) begin
         p1_v_r <= 1'b0;
         p2_v_r <= 1'b0;
         p1_d_r <= 16'd0;
         p2_d_r <= 16'd0;
         dq_o   <= 16'd0;
         dq_oe  <= 1'b0;
      end else if (cke_pad_i) begin
         if (start_s && !issue_rd_s) begin
            p1_v_r <= 1'b0;
            p2_v_r <= 1'b0;
            dq_oe  <= 1'b0;
         end else begin
            p1_v_r <= issue_s && issue_rd_s;
            p1_d_r <= mem_r[ram_addr_s];
            p2_v_r <= p1_v_r;
            p2_d_r <= p1_d_r;
            dq_oe  <= cl3_r ? p2_v_r : p1_v_r;
            dq_o   <= cl3_r ? p2_d_r : p1_d_r;
         end
      end
   end
endmodule
